// File: rtl/key_event_decoder_if.sv
// Keys interface: debounced key level towards the decoder, gesture events towards GUI control.
// Latency: none (plain wires between the two ends).
// Backpressure: none; events are single-cycle pulses that the consumer must sample every cycle.
//
// Signals:
//   key_in       debounced key level (driven by the debounce side)
//   short_press  1-cycle pulse, single press-release with no follow-up press
//   double_click 1-cycle pulse, second short press released
//   long_press   1-cycle pulse, key held for the long-press time
//   repeat_tick  1-cycle pulse, periodic while held after a long press
//   key_held     level, registered pressed state
// Modports:
//   master - the decoder: samples key_in, drives the events
//   slave  - the environment: drives key_in, consumes the events
interface key_event_decoder_if;
  logic key_in;
  logic short_press;
  logic double_click;
  logic long_press;
  logic repeat_tick;
  logic key_held;

  modport master (
    input  key_in,
    output short_press,
    output double_click,
    output long_press,
    output repeat_tick,
    output key_held
  );

  modport slave (
    output key_in,
    input  short_press,
    input  double_click,
    input  long_press,
    input  repeat_tick,
    input  key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short press, double click, long press and auto-repeat.
// Latency: every event pulse is registered, one cycle after the cycle its condition holds.
// Backpressure: none; pulses are fire-and-forget, a consumer that is not listening misses them.
//
// Ports:
//   clk    system clock (same domain as the debounce stage)
//   rst_n  asynchronous reset, active low, released synchronously by the reset tree
//   keys   key_event_decoder_if.master: key_in in, event pulses and key_held out
module key_event_decoder #(
  parameter logic PRESS_LEVEL   = 1'b0,
  parameter int   LONG_CYCLES   = 50_000_000,
  parameter int   DCLICK_CYCLES = 12_500_000,
  parameter int   REPEAT_CYCLES = 5_000_000,
  parameter int   CNT_W         = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  key_event_decoder_if.master        keys
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_key;
  logic             r_key_d;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_dclick;
  logic             r_long;
  logic             r_repeat;

  logic             w_pressed;
  logic             w_press_edge;
  logic             w_release_edge;
  state_t           w_state_nxt;
  logic             w_short_nxt;
  logic             w_dclick_nxt;
  logic             w_long_nxt;
  logic             w_repeat_nxt;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_pressed      = (r_key == PRESS_LEVEL);
  assign w_press_edge   = w_pressed && (r_key_d != PRESS_LEVEL);
  assign w_release_edge = !w_pressed && (r_key_d == PRESS_LEVEL);

  // Key sampling; reset parks both stages at "released" so no edge is seen out of reset
  // unless the key really is down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= ~PRESS_LEVEL;
      r_key_d <= ~PRESS_LEVEL;
    end else begin
      r_key   <= keys.key_in;
      r_key_d <= r_key;
    end
  end

  // Gesture classification. Release is tested before the long-press timeout and press
  // before the double-click timeout, so the user's action wins a same-cycle tie.
  always_comb begin
    w_state_nxt  = r_state;
    w_short_nxt  = 1'b0;
    w_dclick_nxt = 1'b0;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press_edge) begin
          w_state_nxt = S_PRESS1;
        end
      end
      S_PRESS1: begin
        if (w_release_edge) begin
          w_state_nxt = S_WAIT2;
        end else if (w_pressed && (r_cnt == LONG_LAST)) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = S_LONG;
        end
      end
      S_WAIT2: begin
        if (w_press_edge) begin
          w_state_nxt = S_PRESS2;
        end else if (r_cnt == DCLICK_LAST) begin
          w_short_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (w_release_edge) begin
          w_dclick_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_pressed && (r_cnt == LONG_LAST)) begin
          // Held too long for a double click: it becomes a long press instead.
          w_long_nxt  = 1'b1;
          w_state_nxt = S_LONG;
        end
      end
      S_LONG: begin
        if (w_release_edge) begin
          w_state_nxt = S_IDLE;
        end else if (w_pressed && (r_cnt == REPEAT_LAST)) begin
          w_repeat_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The repeat period restarts from zero after each tick even though the state stays put.
  assign w_cnt_clr = w_repeat_nxt || (w_state_nxt != r_state);
  assign w_cnt_nxt = w_cnt_clr        ? '0 :
                     (r_cnt != '1)    ? r_cnt + 1'b1 :
                                        r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_dclick <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_short  <= w_short_nxt;
      r_dclick <= w_dclick_nxt;
      r_long   <= w_long_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  assign keys.short_press  = r_short;
  assign keys.double_click = r_dclick;
  assign keys.long_press   = r_long;
  assign keys.repeat_tick  = r_repeat;
  assign keys.key_held     = w_pressed;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gestures, a duration-based reference model checked
// every cycle, and literal timing expectations per gesture.
// Time scale: 10-unit clock; inputs change 1 unit after posedge, outputs sampled on negedge.
module tb_key_event_decoder;
  localparam int L = 20;
  localparam int D = 8;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  key_event_decoder_if kif();

  key_event_decoder #(
    .PRESS_LEVEL  (1'b0),
    .LONG_CYCLES  (L),
    .DCLICK_CYCLES(D),
    .REPEAT_CYCLES(R),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .keys (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Pulse log, filled by the per-cycle checker.
  int n_short = 0, n_dc = 0, n_long = 0, n_rep = 0;
  int t_short = 0, t_dc = 0, t_long = 0;
  int t_rep [8];

  // Reference model: tracks how long the key has been down / up, not any state encoding.
  bit m_last_kin, m_kr, m_prev, pressed;
  int m_held, m_gap, m_presses;
  bit m_long, m_gap_on;
  bit e_s, e_d, e_l, e_r;

  int bs, bd, bl, br, k, k2;

  function automatic logic [31:0] outs();
    return {27'd0, kif.short_press, kif.double_click, kif.long_press,
            kif.repeat_tick, kif.key_held};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    bs = n_short; bd = n_dc; bl = n_long; br = n_rep;
  endtask

  task automatic model_reset();
    m_last_kin = 1'b1; m_kr = 1'b1; m_prev = 1'b0;
    m_held = 0; m_gap = 0; m_presses = 0;
    m_long = 1'b0; m_gap_on = 1'b0;
    e_s = 1'b0; e_d = 1'b0; e_l = 1'b0; e_r = 1'b0;
  endtask

  // Given the key level seen this cycle, decide which pulse must show next cycle.
  task automatic model_step();
    pressed = (m_kr == 1'b0);
    e_s = 1'b0; e_d = 1'b0; e_l = 1'b0; e_r = 1'b0;
    if (pressed) begin
      if (!m_prev) begin
        if (m_gap_on) begin
          m_presses = 2;
          m_gap_on  = 1'b0;
        end else begin
          m_presses = 1;
        end
        m_held = 1;
      end else begin
        m_held++;
      end
      if (m_long) begin
        if (m_held > L + 1 && ((m_held - L - 1) % R) == 0) e_r = 1'b1;
      end else if (m_held == L + 1) begin
        e_l    = 1'b1;
        m_long = 1'b1;
      end
    end else begin
      if (m_prev) begin
        if (m_long) begin
          m_long = 1'b0; m_presses = 0;
        end else if (m_presses == 2) begin
          e_d = 1'b1; m_presses = 0;
        end else begin
          m_gap_on = 1'b1; m_gap = 1;
        end
      end else if (m_gap_on) begin
        m_gap++;
      end
      if (m_gap_on && m_gap == D + 1) begin
        e_s = 1'b1; m_gap_on = 1'b0; m_presses = 0;
      end
    end
    m_prev = pressed;
  endtask

  initial begin
    model_reset();
    fork
      begin : checker_loop
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            model_reset();
          end else begin
            m_kr       = m_last_kin;
            m_last_kin = kif.key_in;
          end
          n_vec++;
          if (outs() !== {27'd0, e_s, e_d, e_l, e_r, ~m_kr}) begin
            n_err++;
            $display("FAIL outputs cyc=%0d got s/d/l/r/h=%b expected %b",
                     cyc, outs()[4:0], {e_s, e_d, e_l, e_r, ~m_kr});
          end
          if (kif.short_press === 1'b1)  begin n_short++; t_short = cyc; end
          if (kif.double_click === 1'b1) begin n_dc++;    t_dc    = cyc; end
          if (kif.long_press === 1'b1)   begin n_long++;  t_long  = cyc; end
          if (kif.repeat_tick === 1'b1)  begin t_rep[n_rep % 8] = cyc; n_rep++; end
          if (rst_n) model_step();
        end
      end
      begin : stimulus
        kif.key_in = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        tick(3);

        // 1: short press
        snap();
        kif.key_in = 1'b0; tick(5);
        k = cyc; kif.key_in = 1'b1; tick(20);
        check("t1_short_count", n_short - bs, 1);
        check("t1_short_time", t_short - k, 10);
        check("t1_no_other", (n_dc - bd) + (n_long - bl) + (n_rep - br), 0);

        // 2: double click
        snap();
        kif.key_in = 1'b0; tick(5);
        kif.key_in = 1'b1; tick(3);
        kif.key_in = 1'b0; tick(5);
        k = cyc; kif.key_in = 1'b1; tick(20);
        check("t2_dc_count", n_dc - bd, 1);
        check("t2_dc_time", t_dc - k, 2);
        check("t2_no_short", n_short - bs, 0);

        // 3: long press with repeats, silent release
        snap();
        k = cyc; kif.key_in = 1'b0; tick(40);
        kif.key_in = 1'b1; tick(30);
        check("t3_long_count", n_long - bl, 1);
        check("t3_long_time", t_long - k, 22);
        check("t3_rep_count", n_rep - br, 3);
        check("t3_rep1", t_rep[(br + 0) % 8] - t_long, 5);
        check("t3_rep2", t_rep[(br + 1) % 8] - t_long, 10);
        check("t3_rep3", t_rep[(br + 2) % 8] - t_long, 15);
        check("t3_no_other", (n_short - bs) + (n_dc - bd), 0);

        // 4: held one cycle short of the long threshold
        snap();
        kif.key_in = 1'b0; tick(19);
        k = cyc; kif.key_in = 1'b1; tick(20);
        check("t4_no_long", n_long - bl, 0);
        check("t4_short_count", n_short - bs, 1);
        check("t4_short_time", t_short - k, 10);

        // 5: second press lands on the double-click timeout cycle
        snap();
        kif.key_in = 1'b0; tick(5);
        kif.key_in = 1'b1; tick(8);
        kif.key_in = 1'b0; tick(5);
        k2 = cyc; kif.key_in = 1'b1; tick(20);
        check("t5_dc_count", n_dc - bd, 1);
        check("t5_dc_time", t_dc - k2, 2);
        check("t5_no_short", n_short - bs, 0);

        // 6a: reset in the middle of the first press
        kif.key_in = 1'b0; tick(5);
        rst_n = 1'b0; #1;
        check("t6_rst_press1", outs(), 0);
        kif.key_in = 1'b1; tick(3);
        snap();
        rst_n = 1'b1; tick(30);
        check("t6_quiet_after_press1",
              (n_short - bs) + (n_dc - bd) + (n_long - bl) + (n_rep - br), 0);

        // 6b: reset while in the long-press phase
        kif.key_in = 1'b0; tick(25);
        rst_n = 1'b0; #1;
        check("t6_rst_long", outs(), 0);
        kif.key_in = 1'b1; tick(3);
        snap();
        rst_n = 1'b1; tick(30);
        check("t6_quiet_after_long",
              (n_short - bs) + (n_dc - bd) + (n_long - bl) + (n_rep - br), 0);

        // 6c: a fresh gesture still works
        snap();
        kif.key_in = 1'b0; tick(5);
        k = cyc; kif.key_in = 1'b1; tick(20);
        check("t6_fresh_short", n_short - bs, 1);
        check("t6_fresh_time", t_short - k, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    join
  end
endmodule
